io_input_port: RTL and testbench
================================

IO_INPUT_PORT -- requirements
Module: io_input_port

Interface
- REQ-001: The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of cycles an input must hold a new level before it is accepted (10 ms at 50 MHz); legal range 2..2^20.
- REQ-002: The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003: The block SHALL have port i_reset, input, 1 bit: reset, asynchronous and active-high.
- REQ-004: The block SHALL have port i_sw, input, 10 bits: raw asynchronous slide switches, 1 = on.
- REQ-005: The block SHALL have port i_button, input, 4 bits: raw asynchronous push buttons, active-low (0 = pressed).
- REQ-006: The block SHALL have port i_lsu_addr, input, 32 bits: load/store unit byte address.
- REQ-007: The block SHALL have port i_lsu_rden, input, 1 bit: load strobe, valid for one cycle per load.
- REQ-008: The block SHALL have port o_ld_data, output, 32 bits: read data, combinational from i_lsu_addr and registered state.
- REQ-009: The block SHALL have port o_hit, output, 1 bit: 1 when i_lsu_addr decodes to this block.
- REQ-010: The block SHALL have port o_irq, output, 1 bit, present only with IO_INPUT_IRQ_EN (see REQ-027).

Function
- REQ-011: Each of the 14 inputs SHALL pass through a 2-flop synchronizer before any other use.
- REQ-012: Button inputs SHALL be inverted after synchronization so that internal level 1 = pressed.
- REQ-013: Each input SHALL have its own debounce counter (>= 20 bits) and its own stable bit.
- REQ-014: Counter behaviour per input: if synchronized level == stable, counter cleared to 0; otherwise counter increments.
- REQ-015: When the counter equals DEBOUNCE_CYCLES-1 and the level still differs, stable SHALL take the new level on that edge and the counter SHALL clear; total latency from raw change to stable change = 2 + DEBOUNCE_CYCLES cycles.
- REQ-016: A glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave stable unchanged and reset the counter on return; the counter SHALL never wrap.
- REQ-017: A stable button transition 0->1 (press) SHALL set the matching bit of the 4-bit edge-capture register; releases SHALL set nothing.
- REQ-018: Address map, decoded on i_lsu_addr[31:2]: 0x1001_0000 = {22'b0, sw_stable}; 0x1001_1000 = {28'b0, btn_stable}; 0x1001_1004 = {28'b0, edge_capture}.
- REQ-019: Unmapped addresses SHALL give o_hit = 0 and o_ld_data = 0; i_lsu_addr[1:0] SHALL be ignored (word reads only).
- REQ-020: A load (i_lsu_rden = 1) of 0x1001_1004 SHALL return the pre-edge edge_capture value and clear the register on that clock edge (clear-on-read).
- REQ-021: If a new press and a clear-on-read occur on the same edge, the new press bit SHALL be set after the edge (set wins); other bits SHALL clear.
- REQ-022: Reads of the other addresses, and any cycle with i_lsu_rden = 0, SHALL have no side effects.

Reset
- REQ-023: Reset SHALL drive switch synchronizer flops to 0 and button synchronizer flops to 1 (raw released).
- REQ-024: Reset SHALL clear all counters, all stable bits, and edge_capture; with i_lsu_addr unmapped, o_ld_data = 0 and o_hit = 0; o_irq = 0.
- REQ-025: A reset asserted mid-debounce SHALL abandon the pending transition; after release, the input SHALL require a full 2 + DEBOUNCE_CYCLES cycles to be accepted.

Configuration
- REQ-026: The macro IO_INPUT_IRQ_EN SHALL select whether the interrupt output is compiled in.
- REQ-027: With IO_INPUT_IRQ_EN defined, o_irq SHALL be registered and equal |edge_capture one cycle later; without the macro, port o_irq and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification (DEBOUNCE_CYCLES = 8)
- REQ-028: Reset, all raw inputs idle, read 0x1001_0000 / 0x1001_1000 / 0x1001_1004 -> 0 / 0 / 0, o_hit = 1 each.
- REQ-029: i_sw goes from 0 to 0x2A5 and is held -> read of 0x1001_0000 returns 0x2A5 exactly 10 cycles after the change, and 0 at cycle 9.
- REQ-030: i_button[2] pulled low for 5 cycles, then high -> btn_stable and edge_capture remain 0.
- REQ-031: i_button[1] held low -> 0x1001_1000 reads 0x2 and 0x1001_1004 reads 0x2; a second read of 0x1001_1004 returns 0x0; with IO_INPUT_IRQ_EN, o_irq rises the cycle after the capture and falls the cycle after the clear.
- REQ-032: A press of button 3 is accepted on the same edge as a clear-on-read of 0x1001_1004 (value 0x1) -> the read returns 0x1, and the next read returns 0x8.
- REQ-033: Reset is pulsed at debounce count 5 of a pending switch change, then released -> the switch reads 0 until 10 cycles after release, then reads the new value; a read of 0x1000_0000 gives o_hit = 0 and data 0.

Source files
------------

// File: rtl/io_input_port.sv
// Memory-mapped switch/button input port with per-input synchronizer, debounce
// and clear-on-read press capture. Optional interrupt output: IO_INPUT_IRQ_EN.
module io_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [9:0]  i_sw,
  input  logic [3:0]  i_button,
  input  logic [31:0] i_lsu_addr,
  input  logic        i_lsu_rden,
  output logic [31:0] o_ld_data,
  output logic        o_hit
`ifdef IO_INPUT_IRQ_EN
  ,
  output logic        o_irq
`endif
);

  localparam int NUM_SW  = 10;
  localparam int NUM_BTN = 4;
  localparam int NUM_IN  = NUM_SW + NUM_BTN;
  localparam int CW      = 21;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [29:0] SW_WORD   = 30'h0400_4000;
  localparam logic [29:0] BTN_WORD  = 30'h0400_4400;
  localparam logic [29:0] EDGE_WORD = 30'h0400_4401;

  logic [NUM_SW-1:0]  sw_meta;
  logic [NUM_SW-1:0]  sw_sync;
  logic [NUM_BTN-1:0] btn_meta;
  logic [NUM_BTN-1:0] btn_sync;

  logic [NUM_IN-1:0]  level;
  logic [NUM_IN-1:0]  stable;
  logic [NUM_IN-1:0]  accept;
  logic [CW-1:0]      count [NUM_IN];

  logic [NUM_SW-1:0]  sw_stable;
  logic [NUM_BTN-1:0] btn_stable;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] edge_capture;
  logic [29:0]        word_addr;
  logic               read_clear;
  logic               unused_addr_bits;

  assign word_addr        = i_lsu_addr[31:2];
  assign unused_addr_bits = &{1'b0, i_lsu_addr[1:0]};

  // Buttons idle high, so their synchronizers reset to the released level.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '1;
      btn_sync <= '1;
    end else begin
      sw_meta  <= i_sw;
      sw_sync  <= sw_meta;
      btn_meta <= i_button;
      btn_sync <= btn_meta;
    end
  end

  assign level = {~btn_sync, sw_sync};

  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      accept[i] = (level[i] != stable[i]) && (count[i] == LAST_COUNT);
    end
  end

  // Counter runs only while the level disagrees with stable; any agreement
  // clears it, so a short glitch never accumulates toward acceptance.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stable <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (level[i] == stable[i]) begin
          count[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= level[i];
          count[i]  <= '0;
        end else begin
          count[i] <= count[i] + CW'(1);
        end
      end
    end
  end

  assign sw_stable  = stable[NUM_SW-1:0];
  assign btn_stable = stable[NUM_IN-1:NUM_SW];
  assign press      = accept[NUM_IN-1:NUM_SW] & level[NUM_IN-1:NUM_SW];
  assign read_clear = i_lsu_rden && (word_addr == EDGE_WORD);

  // A press landing on the clearing edge survives the clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (read_clear ? '0 : edge_capture) | press;
    end
  end

  always_comb begin
    o_ld_data = '0;
    o_hit     = 1'b0;
    case (word_addr)
      SW_WORD: begin
        o_ld_data = {22'b0, sw_stable};
        o_hit     = 1'b1;
      end
      BTN_WORD: begin
        o_ld_data = {28'b0, btn_stable};
        o_hit     = 1'b1;
      end
      EDGE_WORD: begin
        o_ld_data = {28'b0, edge_capture};
        o_hit     = 1'b1;
      end
      default: begin
        o_ld_data = '0;
        o_hit     = 1'b0;
      end
    endcase
  end

`ifdef IO_INPUT_IRQ_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= |edge_capture;
    end
  end
`endif

endmodule

// File: tb/tb_io_input_port.sv
// Scoreboard bench for io_input_port with DEBOUNCE_CYCLES = 8.
module tb_io_input_port;

  localparam int unsigned DC = 8;
  localparam logic [31:0] A_SW    = 32'h1001_0000;
  localparam logic [31:0] A_BTN   = 32'h1001_1000;
  localparam logic [31:0] A_EDGE  = 32'h1001_1004;
  localparam logic [31:0] A_NONE  = 32'h1000_0000;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [9:0]  i_sw;
  logic [3:0]  i_button;
  logic [31:0] i_lsu_addr;
  logic        i_lsu_rden;
  logic [31:0] o_ld_data;
  logic        o_hit;
`ifdef IO_INPUT_IRQ_EN
  logic        o_irq;
`endif

  int checks   = 0;
  int failures = 0;
  logic [32:0] sb_q [$];

  io_input_port #(.DEBOUNCE_CYCLES(DC)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_sw       (i_sw),
    .i_button   (i_button),
    .i_lsu_addr (i_lsu_addr),
    .i_lsu_rden (i_lsu_rden),
    .o_ld_data  (o_ld_data),
    .o_hit      (o_hit)
`ifdef IO_INPUT_IRQ_EN
    ,
    .o_irq      (o_irq)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Push expectation, then compare against the combinational read at negedge.
  task automatic sample(input string tag, input logic [31:0] exp_data, input logic exp_hit);
    logic [32:0] e;
    sb_q.push_back({exp_hit, exp_data});
    @(negedge i_clk);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_data"}, o_ld_data, e[31:0]);
      chk({tag, "_hit"}, {31'b0, o_hit}, {31'b0, e[32]});
    end
  endtask

  // One-cycle bus access; the clearing edge (if any) is consumed here.
  task automatic rd(input string tag, input logic [31:0] addr, input logic rden,
                    input logic [31:0] exp_data, input logic exp_hit);
    i_lsu_addr = addr;
    i_lsu_rden = rden;
    sample(tag, exp_data, exp_hit);
    tick();
    i_lsu_rden = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
`ifdef IO_INPUT_IRQ_EN
    chk(tag, {31'b0, o_irq}, {31'b0, exp});
`else
    if (tag.len() == 0 && exp) $display("unreachable");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 0, 1);
    $fatal(1, "timeout");
  end

  initial begin
    i_reset    = 1'b1;
    i_sw       = '0;
    i_button   = 4'hF;
    i_lsu_addr = A_NONE;
    i_lsu_rden = 1'b0;
    repeat (3) tick();
    sample("rst_unmapped", 32'h0, 1'b0);
    chk_irq("rst_irq", 1'b0);
    i_reset = 1'b0;
    tick();

    rd("idle_sw", A_SW, 1'b1, 32'h0, 1'b1);
    rd("idle_btn", A_BTN, 1'b1, 32'h0, 1'b1);
    rd("idle_edge", A_EDGE, 1'b1, 32'h0, 1'b1);

    // Switch change: accepted exactly 2 + DC edges later.
    i_sw = 10'h2A5;
    i_lsu_addr = A_SW;
    for (int k = 1; k <= 10; k++) begin
      tick();
      sample($sformatf("sw_lat%0d", k), (k >= 10) ? 32'h2A5 : 32'h0, 1'b1);
    end

    // Short glitch on button 2 must be ignored.
    i_button[2] = 1'b0;
    repeat (5) tick();
    i_button[2] = 1'b1;
    repeat (15) tick();
    rd("glitch_btn", A_BTN, 1'b1, 32'h0, 1'b1);
    rd("glitch_edge", A_EDGE, 1'b1, 32'h0, 1'b1);

    // Button 1 press, capture, clear-on-read, irq timing.
    i_button[1] = 1'b0;
    i_lsu_addr = A_BTN;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 9)  sample("b1_pre", 32'h0, 1'b1);
      if (k == 10) sample("b1_acc", 32'h2, 1'b1);
    end
    chk_irq("irq_lag", 1'b0);
    tick();
    chk_irq("irq_rise", 1'b1);
    rd("b1_edge", A_EDGE, 1'b1, 32'h2, 1'b1);
    chk_irq("irq_hold", 1'b1);
    rd("b1_edge2", A_EDGE, 1'b1, 32'h0, 1'b1);
    chk_irq("irq_fall", 1'b0);
    i_button[1] = 1'b1;
    repeat (12) tick();
    rd("b1_rel_btn", A_BTN, 1'b1, 32'h0, 1'b1);
    rd("b1_rel_edge", A_EDGE, 1'b1, 32'h0, 1'b1);

    // Button 3 accepted on the same edge that clears a captured button 0.
    i_button[0] = 1'b0;
    repeat (12) tick();
    i_button[3] = 1'b0;
    repeat (9) tick();
    rd("setwin_edge", A_EDGE, 1'b1, 32'h1, 1'b1);
    rd("setwin_edge2", A_EDGE, 1'b1, 32'h8, 1'b1);
    rd("setwin_btn", A_BTN, 1'b1, 32'h9, 1'b1);

    // Reset mid-debounce abandons the pending switch change.
    i_sw = 10'h15A;
    i_lsu_addr = A_SW;
    repeat (7) tick();
    sample("mid_sw", 32'h2A5, 1'b1);
    i_reset = 1'b1;
    sample("rst_sw", 32'h0, 1'b1);
    tick();
    i_reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      sample($sformatf("rst_lat%0d", k), (k >= 10) ? 32'h15A : 32'h0, 1'b1);
    end
    rd("unmapped", A_NONE, 1'b1, 32'h0, 1'b0);
    rd("low_bits", A_SW | 32'h3, 1'b1, 32'h15A, 1'b1);
    rd("no_rden", A_EDGE, 1'b0, 32'h9, 1'b1);
    rd("rearm_edge", A_EDGE, 1'b1, 32'h9, 1'b1);
    rd("rearm_edge2", A_EDGE, 1'b1, 32'h0, 1'b1);
    rd("rst_btn", A_BTN, 1'b1, 32'h9, 1'b1);

    if (sb_q.size() != 0) chk("sb_leftover", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
